// File: rtl/input_shift_register_if.sv
// Bundles the executor-side, source-mux and RX FIFO signals of one PIO input
// shift register; master drives instructions, slave is the shift register.
interface input_shift_register_if;
    logic [31:0] in_data;
    logic        in_en;
    logic [4:0]  bit_count;
    logic [31:0] mov_in;
    logic        mov_en;
    logic        push_en;
    logic        push_iffull;
    logic        push_block;
    logic        shiftdir;
    logic        autopush;
    logic [4:0]  push_thresh;
    logic        fifo_full;
    logic [31:0] fifo_data;
    logic        fifo_push;
    logic [31:0] isr_out;
    logic [5:0]  input_shift_counter;
    logic        stall;

    modport master (
        output in_data, in_en, bit_count, mov_in, mov_en, push_en,
               push_iffull, push_block, shiftdir, autopush, push_thresh,
               fifo_full,
        input  fifo_data, fifo_push, isr_out, input_shift_counter, stall
    );

    modport slave (
        input  in_data, in_en, bit_count, mov_in, mov_en, push_en,
               push_iffull, push_block, shiftdir, autopush, push_thresh,
               fifo_full,
        output fifo_data, fifo_push, isr_out, input_shift_counter, stall
    );
endinterface

// File: rtl/input_shift_register.sv
// PIO input shift register: packs IN bits into a 32-bit word and hands
// completed words to the RX FIFO by explicit PUSH or autopush.
module input_shift_register (
    input logic                    clk,
    input logic                    rst,
    input_shift_register_if.slave  bus
);

    logic [31:0] isr;
    logic [5:0]  counter;
    logic [31:0] fifo_data_q;
    logic        fifo_push_q;

    logic [5:0]  n;
    logic [5:0]  thresh;
    logic [6:0]  cnt_sum;
    logic [5:0]  cnt_next;
    logic [31:0] isr_next;
    logic [31:0] in_mask;

    logic        do_mov;
    logic        do_push;
    logic        do_in;
    logic        push_skip;
    logic        autopush_hit;

    logic [31:0] isr_d;
    logic [5:0]  counter_d;
    logic [31:0] fifo_data_d;
    logic        fifo_push_d;
    logic        stall_c;

    // A count of 0 encodes 32 for both the IN width and the push threshold.
    assign n       = (bus.bit_count == 5'd0) ? 6'd32 : {1'b0, bus.bit_count};
    assign thresh  = (bus.push_thresh == 5'd0) ? 6'd32 : {1'b0, bus.push_thresh};
    assign cnt_sum = {1'b0, counter} + {1'b0, n};
    assign cnt_next = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

    always_comb begin
        isr_next = 32'd0;
        in_mask  = 32'd0;
        if (n == 6'd32) begin
            isr_next = bus.in_data;
        end else begin
            in_mask = (32'd1 << n) - 32'd1;
            if (bus.shiftdir)
                isr_next = (isr >> n) | (bus.in_data << (6'd32 - n));
            else
                isr_next = (isr << n) | (bus.in_data & in_mask);
        end
    end

    assign do_mov       = bus.mov_en;
    assign do_push      = !bus.mov_en && bus.push_en;
    assign do_in        = !bus.mov_en && !bus.push_en && bus.in_en;
    assign push_skip    = bus.push_iffull && (counter < thresh);
    assign autopush_hit = do_in && bus.autopush && (cnt_next >= thresh);

    // A stalled cycle leaves every register untouched so the instruction can retry.
    always_comb begin
        isr_d       = isr;
        counter_d   = counter;
        fifo_data_d = fifo_data_q;
        fifo_push_d = 1'b0;
        stall_c     = 1'b0;
        if (do_mov) begin
            isr_d     = bus.mov_in;
            counter_d = 6'd0;
        end else if (do_push) begin
            if (!push_skip) begin
                if (!bus.fifo_full) begin
                    fifo_data_d = isr;
                    fifo_push_d = 1'b1;
                    isr_d       = 32'd0;
                    counter_d   = 6'd0;
                end else if (bus.push_block) begin
                    stall_c = 1'b1;
                end else begin
                    isr_d     = 32'd0;
                    counter_d = 6'd0;
                end
            end
        end else if (do_in) begin
            if (autopush_hit) begin
                if (!bus.fifo_full) begin
                    fifo_data_d = isr_next;
                    fifo_push_d = 1'b1;
                    isr_d       = 32'd0;
                    counter_d   = 6'd0;
                end else begin
                    stall_c = 1'b1;
                end
            end else begin
                isr_d     = isr_next;
                counter_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isr         <= 32'd0;
            counter     <= 6'd0;
            fifo_data_q <= 32'd0;
            fifo_push_q <= 1'b0;
        end else begin
            isr         <= isr_d;
            counter     <= counter_d;
            fifo_data_q <= fifo_data_d;
            fifo_push_q <= fifo_push_d;
        end
    end

    assign bus.isr_out             = isr;
    assign bus.input_shift_counter = counter;
    assign bus.fifo_data           = fifo_data_q;
    assign bus.fifo_push           = fifo_push_q;
    assign bus.stall               = stall_c;

endmodule
